uart_tx_arbiter: RTL and testbench

//  Shares one uart_transmitter among N_REQ byte producers: round-robin grant,

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// A granted byte is latched, started with a one-cycle pulse, and tracked through the frame and idle gap.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int MAX_CNT = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]       LAST_ID   = 3'(N_REQ - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] req_ready_n;
    logic             tx_start_n;
    logic             err_n;
    logic [7:0]       tx_data_n;
    logic [2:0]       grant_n;

    logic             found;
    logic [2:0]       pick;
    logic [7:0]       pick_data;
    logic [7:0]       valid_ext;
    logic [3:0]       sum;

    assign valid_ext = 8'(req_valid);
    assign active    = (state != IDLE);

    // Search starts just after the last grant, so grant_id doubles as the rr pointer.
    always_comb begin
        found = 1'b0;
        pick  = grant_id;
        sum   = 4'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = 4'(grant_id) + 4'(k);
            if (sum >= 4'(N_REQ))
                sum = sum - 4'(N_REQ);
            if (!found && valid_ext[sum[2:0]]) begin
                found = 1'b1;
                pick  = sum[2:0];
            end
        end
    end

    always_comb begin
        pick_data = 8'h00;
        for (int i = 0; i < N_REQ; i++)
            if (pick == 3'(i))
                pick_data = req_data[8*i +: 8];
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_ready_n = '0;
        tx_start_n  = 1'b0;
        err_n       = 1'b0;
        tx_data_n   = tx_data;
        grant_n     = grant_id;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    state_n     = START;
                    req_ready_n = N_REQ'(1) << pick;
                    tx_data_n   = pick_data;
                    grant_n     = pick;
                end
            end
            START: begin
                tx_start_n = 1'b1;
                cnt_n      = '0;
                state_n    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == BUSY_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_n   = '0;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST)
                    state_n = IDLE;
                else
                    cnt_n = cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= LAST_ID;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_ready   <= req_ready_n;
            tx_start    <= tx_start_n;
            err_timeout <= err_n;
            tx_data     <= tx_data_n;
            grant_id    <= grant_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default instance plus a GAP_CYCLES=0 instance,
// with a simple transmitter stand-in that holds tx_busy for a fixed frame length.
module tb_uart_tx_arbiter;

    localparam int FRAME = 10;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;
    logic        err_timeout;

    logic [3:0]  rv0;
    logic [31:0] rd0;
    logic [3:0]  rr0;
    logic        ts0;
    logic [7:0]  td0;
    logic        busy0;
    logic [2:0]  gid0;
    logic        act0;
    logic        err0;

    logic        auto_busy;
    logic        man_busy;
    int          busy_cnt;

    int n_cmp;
    int n_fail;

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(8), .BUSY_TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
    );

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_data(rd0),
        .req_ready(rr0), .tx_start(ts0), .tx_data(td0), .tx_busy(busy0),
        .grant_id(gid0), .active(act0), .err_timeout(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter stand-in: busy for FRAME cycles after each start, cleared by the shared reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= 0;
        else if (auto_busy && tx_start)
            busy_cnt <= FRAME;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = auto_busy ? (busy_cnt != 0) : man_busy;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_cmp++; if (grant_id !== 3'd3) begin n_fail++; $display("[TB] FAIL reset_grant_id: got %0d expected 3", grant_id); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err_timeout); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int w;
        int errs;
        auto_busy = 1'b1;
        req_data  = 32'h000000A5;
        req_valid = 4'b0001;
        tick;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_early: got %b expected 0", tx_start); end
        n_cmp++; if (grant_id !== 3'd0) begin n_fail++; $display("[TB] FAIL single_grant: got %0d expected 0", grant_id); end
        n_cmp++; if (active !== 1'b1) begin n_fail++; $display("[TB] FAIL single_active: got %b expected 1", active); end
        req_valid = 4'b0000;
        tick;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_ready_pulse: got %b expected 0000", req_ready); end
        n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start: got %b expected 1", tx_start); end
        n_cmp++; if (tx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_data: got %h expected a5", tx_data); end
        tick;
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_start_pulse: got %b expected 0", tx_start); end
        w = 0;
        errs = 0;
        while (active !== 1'b0 && w < 60) begin
            tick;
            w++;
            if (err_timeout !== 1'b0) errs++;
        end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done: got active %b expected 0", active); end
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL single_no_err: got %0d pulses expected 0", errs); end
        n_cmp++; if (tx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL single_data_held: got %h expected a5", tx_data); end
    endtask

    task automatic test_round_robin;
        int w;
        int idx;
        logic [7:0] exp_byte;
        do_reset;
        auto_busy = 1'b1;
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            idx = g % 4;
            exp_byte = 8'((idx + 1) * 17);
            w = 0;
            while (req_ready === 4'b0000 && w < 40) begin
                tick;
                w++;
            end
            n_cmp++; if (req_ready !== 4'(1 << idx)) begin n_fail++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", g, req_ready, 4'(1 << idx)); end
            if (g > 0) begin
                n_cmp++; if (w != 10) begin n_fail++; $display("[TB] FAIL rr_gap[%0d]: got %0d cycles expected 10", g, w); end
            end
            n_cmp++; if (grant_id !== 3'(idx)) begin n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", g, grant_id, idx); end
            if (g == 4) req_valid = 4'b0000;
            tick;
            n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_start[%0d]: got %b expected 1", g, tx_start); end
            n_cmp++; if (tx_data !== exp_byte) begin n_fail++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", g, tx_data, exp_byte); end
            w = 0;
            while (tx_busy !== 1'b1 && w < 10) begin tick; w++; end
            w = 0;
            while (tx_busy !== 1'b0 && w < 40) begin tick; w++; end
        end
        w = 0;
        while (active !== 1'b0 && w < 40) begin tick; w++; end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_idle: got active %b expected 0", active); end
    endtask

    task automatic test_gap_zero;
        int w;
        rv0 = 4'b0100;
        rd0 = 32'h005C0000;
        tick;
        n_cmp++; if (rr0 !== 4'b0100) begin n_fail++; $display("[TB] FAIL gap0_ready: got %b expected 0100", rr0); end
        n_cmp++; if (gid0 !== 3'd2) begin n_fail++; $display("[TB] FAIL gap0_grant: got %0d expected 2", gid0); end
        tick;
        n_cmp++; if (ts0 !== 1'b1) begin n_fail++; $display("[TB] FAIL gap0_start: got %b expected 1", ts0); end
        n_cmp++; if (td0 !== 8'h5C) begin n_fail++; $display("[TB] FAIL gap0_data: got %h expected 5c", td0); end
        busy0 = 1'b1;
        repeat (5) tick;
        busy0 = 1'b0;
        w = 0;
        while (ts0 !== 1'b1 && w < 10) begin tick; w++; end
        n_cmp++; if (w != 3) begin n_fail++; $display("[TB] FAIL gap0_latency: got %0d cycles expected 3", w); end
        n_cmp++; if (gid0 !== 3'd2) begin n_fail++; $display("[TB] FAIL gap0_regrant: got %0d expected 2", gid0); end
        rv0 = 4'b0000;
        busy0 = 1'b1;
        tick;
        tick;
        busy0 = 1'b0;
        w = 0;
        while (act0 !== 1'b0 && w < 10) begin tick; w++; end
        n_cmp++; if (act0 !== 1'b0) begin n_fail++; $display("[TB] FAIL gap0_idle: got active %b expected 0", act0); end
    endtask

    task automatic test_timeout;
        int errs;
        auto_busy = 1'b0;
        man_busy  = 1'b0;
        req_data  = 32'h00C30000;
        req_valid = 4'b0100;
        tick;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL tmo_ready: got %b expected 0100", req_ready); end
        req_valid = 4'b0000;
        tick;
        n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("[TB] FAIL tmo_start: got %b expected 1", tx_start); end
        errs = 0;
        repeat (3) begin
            tick;
            if (err_timeout !== 1'b0) errs++;
        end
        n_cmp++; if (errs != 0) begin n_fail++; $display("[TB] FAIL tmo_early: got %0d pulses expected 0", errs); end
        tick;
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL tmo_pulse: got %b expected 1", err_timeout); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_active: got %b expected 0", active); end
        tick;
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_single: got %b expected 0", err_timeout); end
        n_cmp++; if (grant_id !== 3'd2) begin n_fail++; $display("[TB] FAIL tmo_grant: got %0d expected 2", grant_id); end
    endtask

    task automatic test_reset_mid_frame;
        int w;
        auto_busy = 1'b1;
        req_data  = 32'h7E000000;
        req_valid = 4'b1000;
        tick;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL rstmid_ready: got %b expected 1000", req_ready); end
        req_valid = 4'b0010;
        req_data  = 32'h7E009B00;
        tick;
        w = 0;
        while (tx_busy !== 1'b1 && w < 10) begin tick; w++; end
        tick;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rstmid_no_grant: got %b expected 0000", req_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_active: got %b expected 0", active); end
        n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_start: got %b expected 0", tx_start); end
        n_cmp++; if (grant_id !== 3'd3) begin n_fail++; $display("[TB] FAIL rstmid_grant: got %0d expected 3", grant_id); end
        n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rstmid_data: got %h expected 00", tx_data); end
        tick;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL rstmid_regrant: got %b expected 0010", req_ready); end
        n_cmp++; if (grant_id !== 3'd1) begin n_fail++; $display("[TB] FAIL rstmid_regrant_id: got %0d expected 1", grant_id); end
        req_valid = 4'b0000;
        tick;
        n_cmp++; if (tx_data !== 8'h9B) begin n_fail++; $display("[TB] FAIL rstmid_regrant_data: got %h expected 9b", tx_data); end
        w = 0;
        while (active !== 1'b0 && w < 60) begin tick; w++; end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_idle: got active %b expected 0", active); end
    endtask

    task automatic test_dropped_request;
        int w;
        logic [3:0] seen;
        auto_busy = 1'b1;
        req_data  = 32'h0000003C;
        req_valid = 4'b0001;
        tick;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL drop_first: got %b expected 0001", req_ready); end
        req_valid = 4'b0000;
        tick;
        w = 0;
        while (tx_busy !== 1'b1 && w < 10) begin tick; w++; end
        tick;
        req_valid = 4'b0010;
        tick;
        req_valid = 4'b0000;
        seen = 4'b0000;
        repeat (40) begin
            tick;
            seen = seen | req_ready;
        end
        n_cmp++; if (seen !== 4'b0000) begin n_fail++; $display("[TB] FAIL drop_no_ready: got %b expected 0000", seen); end
        n_cmp++; if (grant_id !== 3'd0) begin n_fail++; $display("[TB] FAIL drop_grant: got %0d expected 0", grant_id); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_idle: got active %b expected 0", active); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        rv0       = 4'b0000;
        rd0       = 32'h0;
        busy0     = 1'b0;
        auto_busy = 1'b0;
        man_busy  = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_gap_zero;
        test_timeout;
        test_reset_mid_frame;
        test_dropped_request;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
